lbp_hist_accum: RTL and testbench
=================================

Name: lbp_hist_accum

Overview:
- Downstream consumer of the LBP engine's write interface (lbp_valid/lbp_addr/lbp_data/finish).
- Builds a 256-bin histogram of LBP codes for one 128x128 frame; only the 126x126 interior is ever written.
- On the producer's finish, drains the pipeline and streams all 256 bin counts out over a valid/ready port.
- Clears each bin as it is read, so the next frame starts from zero with no re-clear.

Parameters:
- NBINS, 256, number of histogram bins; equals 2^8 LBP codes; fixed.
- CNT_W, 14, bin counter width; 2^14-1 covers 126*126 = 15876.
- ADDR_W, 14, width of lbp_addr = {row[6:0], col[6:0]}.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- lbp_valid  in  1  one-cycle write strobe from the LBP engine.
- lbp_addr  in  14  pixel address; used only for the ROI option.
- lbp_data  in  8  LBP code = bin index.
- finish  in  1  frame end; may coincide with the last lbp_valid.
- hist_valid  out  1  hist_bin/hist_count valid.
- hist_ready  in  1  downstream accepts the current bin.
- hist_bin  out  8  bin index being output.
- hist_count  out  CNT_W  count for hist_bin.
- hist_done  out  1  one-cycle pulse when bin 255 is accepted.
- px_count  out  CNT_W  samples accumulated in the current frame (saturating).
- busy  out  1  high in every state except ACCUM.
- err  out  1  sticky; lbp_valid was seen while busy. Cleared only by reset.

Behaviour:
- Reset values: hist_valid=0, hist_bin=0, hist_count=0, hist_done=0, px_count=0, busy=1, err=0. FSM enters CLEAR.
- Storage: 256 x CNT_W single-port-write / synchronous-read RAM, or a flop array.
- CLEAR:
  - Writes 0 to bins 0..255, one per cycle: exactly 256 cycles.
  - Then goes to ACCUM; busy falls on the first ACCUM cycle.
- ACCUM: read-modify-write pipeline.
  - T: sample lbp_data.
  - T+1: read bin.
  - T+2: write count+1.
  - Accepts lbp_valid every cycle.
  - Back-to-back hits on the same bin (distance 1 or 2) are forwarded; no increment may be lost.
  - Each count saturates at 2^CNT_W-1.
  - px_count increments per accepted sample and saturates.
- finish sampled in ACCUM (with or without lbp_valid in the same cycle):
  - Any same-cycle sample is accepted.
  - Go to DRAIN.
- DRAIN: 2 cycles for the pipeline to complete, then READOUT with bin pointer = 0.
- READOUT:
  - hist_valid is high with hist_bin = ptr and hist_count = bin value.
  - Hold both stable while hist_ready=0.
  - On valid&&ready: write 0 to the bin, then ptr+1.
  - The next bin is presented no later than 2 cycles after acceptance.
  - Gaps (hist_valid low) are allowed between bins.
  - After bin 255 is accepted: hist_done pulses for 1 cycle, px_count clears to 0, return to ACCUM.
- lbp_valid in CLEAR, DRAIN or READOUT: sample dropped, err set.
- finish outside ACCUM: ignored.
- Reset mid-operation: all outputs return to reset values immediately; CLEAR restarts.

Optional Feature:
- Macro: LBP_HIST_ROI_EN.
- When defined, adds inputs roi_row_min, roi_row_max, roi_col_min, roi_col_max (7 bits each), sampled every cycle.
- A sample is accumulated only if roi_row_min <= lbp_addr[13:7] <= roi_row_max and roi_col_min <= lbp_addr[6:0] <= roi_col_max.
- Samples outside the ROI are silently discarded: no count, no px_count, no err.
- An empty ROI (min > max) accumulates nothing.
- When undefined: no ROI ports; lbp_addr is ignored apart from the pipeline.

Test Plan:
- Reset released -> busy=1 for exactly 256 clk cycles, then 0. Immediate finish -> readout of 256 bins, all count 0, hist_done pulse, px_count=0.
- Three consecutive-cycle lbp_valid with data=0x5A, then finish -> bin 0x5A count=3, all other bins 0, px_count=3.
- lbp_valid data=0xFF in the same cycle as finish -> bin 255 count=1; sample not lost.
- Readout with hist_ready randomly toggled -> bins 0..255 each delivered exactly once, in order; hist_bin/hist_count stable while stalled; one hist_done pulse.
- Full 126x126 frame, every code 0x00, then a second frame of alternating 0x01/0x02 -> frame 1: bin0=15876. Frame 2: bin0=0, bin1=7938, bin2=7938.
- lbp_valid during READOUT -> err=1, counts unchanged. Reset asserted mid-readout -> hist_valid=0 and err=0 immediately; 256-cycle CLEAR repeats.

Source files
------------

// File: rtl/lbp_hist_if.sv
// Bus bundle between the LBP engine, the histogram accumulator and its consumer.
// It carries the write strobe side (lbp_*/finish) and the valid/ready histogram stream.
interface lbp_hist_if #(
    parameter int CNT_W  = 14,
    parameter int ADDR_W = 14
);
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              finish;
    logic              hist_valid;
    logic              hist_ready;
    logic [7:0]        hist_bin;
    logic [CNT_W-1:0]  hist_count;
    logic              hist_done;

    // Producer of LBP samples and consumer of the histogram stream.
    modport master (
        output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        input  hist_valid, hist_bin, hist_count, hist_done
    );

    // The histogram accumulator.
    modport slave (
        input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        output hist_valid, hist_bin, hist_count, hist_done
    );
endinterface

// File: rtl/lbp_hist_accum.sv
// 256-bin LBP code histogram for one frame.
// CLEAR zeroes the RAM (256 cycles), ACCUM runs a sample/read/write pipeline with
// forwarding, DRAIN lets it settle, READOUT streams the bins out and zeroes each one
// as it is accepted so the next frame starts clean.
// Optional region-of-interest filter: define LBP_HIST_ROI_EN.
module lbp_hist_accum #(
    parameter int NBINS  = 256,
    parameter int CNT_W  = 14,
    parameter int ADDR_W = 14
) (
    input  logic             clk,
    input  logic             reset,
`ifdef LBP_HIST_ROI_EN
    input  logic [6:0]       roi_row_min,
    input  logic [6:0]       roi_row_max,
    input  logic [6:0]       roi_col_min,
    input  logic [6:0]       roi_col_max,
`endif
    lbp_hist_if.slave        bus,
    output logic [CNT_W-1:0] px_count,
    output logic             busy,
    output logic             err
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [7:0]       LAST_BIN = 8'(NBINS - 1);

    typedef enum logic [1:0] {ST_CLEAR, ST_ACCUM, ST_DRAIN, ST_READOUT} state_t;

    state_t           state_reg, state_next;
    logic [7:0]       ptr_reg, ptr_next;
    logic             drain_reg, drain_next;

    // Increment pipeline: s1 = sampled code (RAM read issued), s2 = read data back (write issued)
    logic             s1_valid_reg, s2_valid_reg;
    logic [7:0]       s1_bin_reg, s2_bin_reg;
    logic             fwd_hit_reg;
    logic [CNT_W-1:0] fwd_val_reg;

    logic [CNT_W-1:0] mem [NBINS];
    logic [CNT_W-1:0] rd_data_reg;
    logic             mem_we;
    logic [7:0]       mem_waddr, mem_raddr;
    logic [CNT_W-1:0] mem_wdata;

    logic             fetch_reg, hist_valid_reg, hist_done_reg, err_reg;
    logic [CNT_W-1:0] hist_count_reg, px_count_reg;
    logic [CNT_W-1:0] base_cnt, inc_cnt;
    logic             roi_ok, sample_take, bin_accept, last_accept;

`ifdef LBP_HIST_ROI_EN
    logic [6:0] addr_row, addr_col;
    assign addr_row = bus.lbp_addr[13:7];
    assign addr_col = bus.lbp_addr[6:0];
    // An empty window (min > max) can never satisfy both bounds, so it drops everything.
    assign roi_ok = (addr_row >= roi_row_min) && (addr_row <= roi_row_max) &&
                    (addr_col >= roi_col_min) && (addr_col <= roi_col_max);
`else
    logic unused_addr;
    assign roi_ok      = 1'b1;
    assign unused_addr = ^bus.lbp_addr;
`endif

    assign sample_take = bus.lbp_valid && (state_reg == ST_ACCUM) && roi_ok;
    assign bin_accept  = (state_reg == ST_READOUT) && hist_valid_reg && bus.hist_ready;
    assign last_accept = bin_accept && (ptr_reg == LAST_BIN);

    // The RAM read at the same edge as the previous write to the same bin is stale,
    // so that one case takes the value being written instead.
    assign base_cnt = fwd_hit_reg ? fwd_val_reg : rd_data_reg;
    assign inc_cnt  = (base_cnt == CNT_MAX) ? CNT_MAX : base_cnt + CNT_W'(1);

    // Next-state logic: clear sweep, accumulate, two-cycle drain, readout sweep.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        drain_next = 1'b0;
        unique case (state_reg)
            ST_CLEAR: begin
                ptr_next = ptr_reg + 8'd1;
                if (ptr_reg == LAST_BIN) state_next = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (bus.finish) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                drain_next = 1'b1;
                if (drain_reg) begin
                    drain_next = 1'b0;
                    ptr_next   = '0;
                    state_next = ST_READOUT;
                end
            end
            ST_READOUT: begin
                if (bin_accept) begin
                    ptr_next = ptr_reg + 8'd1;
                    if (ptr_reg == LAST_BIN) state_next = ST_ACCUM;
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    // State, shared bin pointer and drain counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_CLEAR;
            ptr_reg   <= '0;
            drain_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            drain_reg <= drain_next;
        end
    end

    // RAM port steering: zero-writes from clear/readout, otherwise the pipeline write.
    // During readout the next bin is prefetched on the accept edge.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = s2_bin_reg;
        mem_wdata = inc_cnt;
        if ((state_reg == ST_CLEAR) || bin_accept) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_reg;
            mem_wdata = '0;
        end else if (s2_valid_reg) begin
            mem_we = 1'b1;
        end
        mem_raddr = s1_bin_reg;
        if (state_reg == ST_READOUT) mem_raddr = bin_accept ? (ptr_reg + 8'd1) : ptr_reg;
    end

    // Bin storage with registered read (no reset: CLEAR initialises the contents).
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        rd_data_reg <= mem[mem_raddr];
    end

    // Sample -> read -> write pipeline with distance-1 hazard detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_bin_reg   <= '0;
            s2_valid_reg <= 1'b0;
            s2_bin_reg   <= '0;
            fwd_hit_reg  <= 1'b0;
            fwd_val_reg  <= '0;
        end else begin
            s1_valid_reg <= sample_take;
            s1_bin_reg   <= bus.lbp_data;
            s2_valid_reg <= s1_valid_reg;
            s2_bin_reg   <= s1_bin_reg;
            fwd_hit_reg  <= s1_valid_reg && s2_valid_reg && (s1_bin_reg == s2_bin_reg);
            fwd_val_reg  <= inc_cnt;
        end
    end

    // Readout presentation: fetch cycle, then hold bin/count until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_reg      <= 1'b0;
            hist_valid_reg <= 1'b0;
            hist_count_reg <= '0;
            hist_done_reg  <= 1'b0;
        end else begin
            hist_done_reg <= last_accept;
            if (state_reg != ST_READOUT) begin
                fetch_reg      <= 1'b0;
                hist_valid_reg <= 1'b0;
            end else if (bin_accept) begin
                hist_valid_reg <= 1'b0;
                fetch_reg      <= !last_accept;
            end else if (!hist_valid_reg && fetch_reg) begin
                hist_valid_reg <= 1'b1;
                hist_count_reg <= rd_data_reg;
                fetch_reg      <= 1'b0;
            end else if (!hist_valid_reg) begin
                fetch_reg <= 1'b1;
            end
        end
    end

    // Saturating sample counter and sticky error for writes while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_count_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (last_accept) px_count_reg <= '0;
            else if (sample_take && (px_count_reg != CNT_MAX)) px_count_reg <= px_count_reg + CNT_W'(1);
            if (bus.lbp_valid && (state_reg != ST_ACCUM)) err_reg <= 1'b1;
        end
    end

    assign bus.hist_valid = hist_valid_reg;
    assign bus.hist_bin   = (state_reg == ST_READOUT) ? ptr_reg : 8'd0;
    assign bus.hist_count = hist_count_reg;
    assign bus.hist_done  = hist_done_reg;
    assign px_count       = px_count_reg;
    assign busy           = (state_reg != ST_ACCUM);
    assign err            = err_reg;
endmodule

// File: tb/tb_lbp_hist_accum.sv
// Self-checking bench for lbp_hist_accum: table-driven frames, randomized frames
// against an array histogram model, full 126x126 frames, error and reset cases.
module tb_lbp_hist_accum;
    localparam int CNT_W   = 14;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [CNT_W-1:0] px_count;
    logic             busy, err;

    lbp_hist_if #(.CNT_W(CNT_W), .ADDR_W(14)) bus ();

    always #5 clk = ~clk;

    lbp_hist_accum #(.NBINS(256), .CNT_W(CNT_W), .ADDR_W(14)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef LBP_HIST_ROI_EN
        .roi_row_min(7'd0),
        .roi_row_max(7'd127),
        .roi_col_min(7'd0),
        .roi_col_max(7'd127),
`endif
        .bus        (bus),
        .px_count   (px_count),
        .busy       (busy),
        .err        (err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int model_hist [256];
    int model_px;
    int got_hist   [256];

    typedef struct {
        logic [7:0] data;
        int         n;
        int         gap;
        bit         fin_last;
        int         exp_count;
        int         exp_px;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 256; i++) model_hist[i] = 0;
        model_px = 0;
    endfunction

    function automatic void model_add(input int d);
        if (model_hist[d] < CNT_MAX) model_hist[d]++;
        if (model_px < CNT_MAX) model_px++;
    endfunction

    // One clock cycle of producer activity.
    task automatic drive(input bit v, input logic [7:0] d, input logic [13:0] a, input bit f);
        @(posedge clk);
        #1;
        bus.lbp_valid = v;
        bus.lbp_data  = d;
        bus.lbp_addr  = a;
        bus.finish    = f;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 14'h0, 1'b0);
    endtask

    // Release reset and measure how long busy stays high.
    task automatic release_and_count();
        int n;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("clear_busy_cycles", n, 256);
    endtask

    // Consume all 256 bins, checking order, values, stall stability and the done pulse.
    task automatic readout(input bit rnd);
        int idx, cyc, low, held_bin, held_cnt;
        bit stalled;
        idx = 0; cyc = 0; low = 0; stalled = 0; held_bin = 0; held_cnt = 0;
        while (idx < 256 && cyc < 4000) begin
            @(posedge clk);
            #1;
            bus.hist_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            cyc++;
            if (bus.hist_valid) begin
                if (stalled) begin
                    chk("stall_bin", bus.hist_bin, held_bin);
                    chk("stall_count", bus.hist_count, held_cnt);
                end else if (idx > 0) begin
                    chk("next_bin_latency", int'(low <= 2), 1);
                end
                low = 0;
                if (bus.hist_ready) begin
                    chk("bin_order", bus.hist_bin, idx);
                    chk("bin_count", bus.hist_count, model_hist[idx]);
                    got_hist[idx] = bus.hist_count;
                    idx++;
                    stalled = 0;
                end else begin
                    stalled  = 1;
                    held_bin = bus.hist_bin;
                    held_cnt = bus.hist_count;
                end
            end else begin
                if (stalled) chk("stall_valid_held", bus.hist_valid, 1);
                stalled = 0;
                low++;
            end
        end
        if (idx < 256) chk("readout_timeout_bins", idx, 256);
        @(posedge clk);
        #1;
        bus.hist_ready = 1'b0;
        @(negedge clk);
        chk("done_pulse", bus.hist_done, 1);
        chk("px_after_done", px_count, 0);
        chk("busy_after_done", busy, 0);
        chk("valid_after_done", bus.hist_valid, 0);
        @(negedge clk);
        chk("done_one_cycle", bus.hist_done, 0);
        model_clear();
    endtask

    initial begin
        vec_t       vecs [5];
        logic [7:0] d;
        bit         last;
        int         n, k;

        vecs[0] = '{8'h00, 0, 0, 1'b0, 0, 0};
        vecs[1] = '{8'h5A, 3, 0, 1'b0, 3, 3};
        vecs[2] = '{8'hFF, 1, 0, 1'b1, 1, 1};
        vecs[3] = '{8'h33, 5, 1, 1'b0, 5, 5};
        vecs[4] = '{8'h80, 4, 2, 1'b1, 4, 4};

        bus.lbp_valid  = 1'b0;
        bus.lbp_data   = 8'h00;
        bus.lbp_addr   = 14'h0;
        bus.finish     = 1'b0;
        bus.hist_ready = 1'b0;
        reset          = 1'b1;
        model_clear();
        for (int i = 0; i < 256; i++) got_hist[i] = -1;

        #1;
        chk("rst_busy", busy, 1);
        chk("rst_hist_valid", bus.hist_valid, 0);
        chk("rst_hist_bin", bus.hist_bin, 0);
        chk("rst_hist_count", bus.hist_count, 0);
        chk("rst_hist_done", bus.hist_done, 0);
        chk("rst_px_count", px_count, 0);
        chk("rst_err", err, 0);
        repeat (3) @(posedge clk);
        release_and_count();

        // Table-driven frames: one code, several spacings, finish separate or coincident.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                last = (i == vecs[v].n - 1);
                drive(1'b1, vecs[v].data, 14'($urandom), vecs[v].fin_last && last);
                model_add(vecs[v].data);
                if (!(vecs[v].fin_last && last)) repeat (vecs[v].gap) idle();
            end
            if (vecs[v].n == 0 || !vecs[v].fin_last) drive(1'b0, 8'h00, 14'h0, 1'b1);
            idle();
            @(negedge clk);
            chk("vec_px_count", px_count, vecs[v].exp_px);
            readout(v[0]);
            chk("vec_bin_count", got_hist[vecs[v].data], vecs[v].exp_count);
            $display("vector %0d: bin 0x%02h count %0d px %0d", v, vecs[v].data,
                     got_hist[vecs[v].data], vecs[v].exp_px);
        end
        chk("err_clean", err, 0);

        // Randomized frames with hazard-heavy codes and random gaps.
        for (int f = 0; f < 2; f++) begin
            n = 300 + $urandom_range(0, 200);
            for (int i = 0; i < n; i++) begin
                d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
                last = (i == n - 1) && (f == 0);
                drive(1'b1, d, 14'($urandom), last);
                model_add(d);
                if ($urandom_range(0, 2) == 0) idle();
            end
            if (f != 0) drive(1'b0, 8'h00, 14'h0, 1'b1);
            idle();
            @(negedge clk);
            chk("rand_px_count", px_count, model_px);
            readout(1'b1);
            $display("random frame %0d: %0d samples", f, n);
        end

        // Full interior frame of code 0x00.
        for (int r = 1; r <= 126; r++) begin
            for (int c = 1; c <= 126; c++) begin
                drive(1'b1, 8'h00, {7'(r), 7'(c)}, (r == 126) && (c == 126));
                model_add(0);
            end
        end
        idle();
        @(negedge clk);
        chk("frame1_px", px_count, 15876);
        readout(1'b1);
        chk("frame1_bin0", got_hist[0], 15876);
        $display("full frame 1: bin0 %0d", got_hist[0]);

        // Second full frame alternating 0x01/0x02.
        k = 0;
        for (int r = 1; r <= 126; r++) begin
            for (int c = 1; c <= 126; c++) begin
                d = (k % 2 == 0) ? 8'h01 : 8'h02;
                drive(1'b1, d, {7'(r), 7'(c)}, 1'b0);
                model_add(d);
                k++;
            end
        end
        drive(1'b0, 8'h00, 14'h0, 1'b1);
        idle();
        @(negedge clk);
        chk("frame2_px", px_count, 15876);
        readout(1'b0);
        chk("frame2_bin0", got_hist[0], 0);
        chk("frame2_bin1", got_hist[1], 7938);
        chk("frame2_bin2", got_hist[2], 7938);
        $display("full frame 2: bin1 %0d bin2 %0d", got_hist[1], got_hist[2]);

        // A write strobe during readout is dropped and flagged.
        drive(1'b1, 8'h10, 14'h0, 1'b0);
        model_add(8'h10);
        drive(1'b0, 8'h00, 14'h0, 1'b1);
        idle();
        n = 0;
        @(negedge clk);
        while (!bus.hist_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("readout_started", bus.hist_valid, 1);
        drive(1'b1, 8'h10, 14'h0, 1'b0);
        idle();
        @(negedge clk);
        chk("err_set", err, 1);
        readout(1'b1);
        chk("err_bin_unchanged", got_hist[8'h10], 1);
        chk("err_sticky", err, 1);
        $display("error frame: bin 0x10 count %0d err %0d", got_hist[8'h10], err);

        // Reset in the middle of a readout.
        drive(1'b1, 8'h77, 14'h0, 1'b0);
        drive(1'b1, 8'h77, 14'h0, 1'b0);
        drive(1'b0, 8'h00, 14'h0, 1'b1);
        idle();
        bus.hist_ready = 1'b1;
        repeat (12) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_hist_valid", bus.hist_valid, 0);
        chk("midrst_hist_bin", bus.hist_bin, 0);
        chk("midrst_err", err, 0);
        chk("midrst_busy", busy, 1);
        chk("midrst_px", px_count, 0);
        bus.hist_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        release_and_count();

        // Empty frame after the restart: the clear sweep must have wiped bin 0x77.
        drive(1'b0, 8'h00, 14'h0, 1'b1);
        idle();
        readout(1'b1);
        chk("post_reset_bin77", got_hist[8'h77], 0);
        $display("post-reset frame: bin 0x77 count %0d", got_hist[8'h77]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
